// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/requester types and default sizing for the
// memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_t;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts stalled BUSY cycles of one memory access and flags
// the stalled cycle on which the count reaches TIMEOUT (1..255).
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // Stall counter: zeroed while clear is high, advanced on each enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Expiry is flagged during the stalled cycle that takes the count to TIMEOUT,
    // so a completion in that same cycle (enable low) still wins.
    assign expired = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a data
// requester, with a per-access timeout abort.
// Optional feature: define ARB_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise data requests have fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy;
    logic              expired;
`ifdef ARB_RR_EN
    req_t              last_gnt;
`endif

    assign busy = (state != IDLE);

    // Grant decision: only in IDLE and out of reset, at most one winner.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n && state == IDLE) begin
            if (d_req && if_req) begin
`ifdef ARB_RR_EN
                if (last_gnt == REQ_D) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
`else
                d_gnt = 1'b1;
`endif
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req;
            end
        end
    end

    mem_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!busy),
        .enable (busy && !mem_ready),
        .expired(expired)
    );

    // Access FSM: capture on grant, complete or abort, then pulse the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            resp_err <= 1'b0;
`ifdef ARB_RR_EN
            last_gnt <= REQ_IF;
`endif
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            resp_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_gnt) begin
                        state   <= BUSY_D;
                        addr_q  <= d_addr;
                        we_q    <= d_we;
                        wdata_q <= d_wdata;
`ifdef ARB_RR_EN
                        last_gnt <= REQ_D;
`endif
                    end else if (if_gnt) begin
                        state   <= BUSY_IF;
                        addr_q  <= if_addr;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
`ifdef ARB_RR_EN
                        last_gnt <= REQ_IF;
`endif
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        rdata_q <= we_q ? '0 : mem_rdata;
                        if (state == BUSY_IF) begin
                            if_valid <= 1'b1;
                        end else begin
                            d_valid <= 1'b1;
                        end
                    end else if (expired) begin
                        state    <= IDLE;
                        rdata_q  <= '0;
                        resp_err <= 1'b1;
                        if (state == BUSY_IF) begin
                            if_valid <= 1'b1;
                        end else begin
                            d_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = rdata_q;
    assign d_rdata   = rdata_q;

endmodule
